// File: rtl/serial_adder_seq.sv
// Bit-serial N-bit adder: operands load in parallel, one sum bit is produced per
// clock LSB-first through a half-adder/half-adder/OR full-adder cell and a carry
// flip-flop, and the result is published in parallel with a one-cycle done pulse.
module serial_adder_seq #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    opa_q, opa_d;
    logic [N-1:0]    opb_q, opb_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            ha0_s, ha0_c, ha1_s, ha1_c;
    logic            fa_s, fa_c;
    logic [N-1:0]    acc_shift;

    // Full-adder cell on the current LSBs, and the accumulator with the new bit shifted in
    // from the top (written as a shift so that N=1 needs no special case).
    always_comb begin
        ha0_s     = opa_q[0] ^ opb_q[0];
        ha0_c     = opa_q[0] & opb_q[0];
        ha1_s     = ha0_s ^ carry_q;
        ha1_c     = ha0_s & carry_q;
        fa_s      = ha1_s;
        fa_c      = ha0_c | ha1_c;
        acc_shift = acc_q >> 1;
        acc_shift[N-1] = fa_s;
    end

    // Next-state: load on accepted start, shift one bit per edge, publish on the last bit.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                carry_d = fa_c;
                acc_d   = acc_shift;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    // sum/cout only ever change here, so no partial result is visible.
                    sum_d   = acc_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous reset discarding any in-flight addition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and randomised bench for serial_adder_seq at N=8, N=1 and N=13.
module tb_serial_adder_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=8 instance
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // N=1 instance
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    // N=13 instance
    logic        start13 = 1'b0, cin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        busy13, done13, cout13;
    logic [12:0] sum13;

    serial_adder_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_seq #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder_seq #(.N(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_sum = '0;
    logic       last_cout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // One complete N=8 addition with protocol and result checks.
    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec);
        int cyc;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy8), 32'd1);
        check({name, "_sum_holds_while_busy"}, 32'(sum8), 32'(last_sum));
        wait_done8(cyc);
        check({name, "_done"}, 32'(done8), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'd8);
        check({name, "_busy_at_done"}, 32'(busy8), 32'd0);
        check({name, "_sum"}, 32'(sum8), 32'(es));
        check({name, "_cout"}, 32'(cout8), 32'(ec));
        last_sum = es; last_cout = ec;
        tick();
        check({name, "_done_one_cycle"}, 32'(done8), 32'd0);
        check({name, "_sum_held"}, 32'(sum8), 32'(es));
    endtask

    vec_t vecs[8];

    initial begin
        int cyc, elapsed;
        logic seen_done;
        logic [8:0]  e9;
        logic [1:0]  e2;
        logic [13:0] e14;
        logic [7:0]  ra, rb;
        logic        rc;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, exp_sum: 8'h96, exp_cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp_sum: 8'h01, exp_cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, exp_sum: 8'h80, exp_cout: 1'b0};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b0, exp_sum: 8'h46, exp_cout: 1'b0};

        // Reset state, before any clock edge
        #2;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                 vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // start pulse with new operands during busy is ignored
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'hAA; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'h00;
        wait_done8(cyc);
        check("ignore_done", 32'(done8), 32'd1);
        check("ignore_latency", 32'(cyc + 3), 32'd8);
        check("ignore_sum", 32'(sum8), 32'h30);
        check("ignore_cout", 32'(cout8), 32'd0);
        last_sum = 8'h30; last_cout = 1'b0;
        tick();

        // Asynchronous reset between clock edges, mid-add, after a nonzero result
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy8), 32'd0);
        check("async_rst_done", 32'(done8), 32'd0);
        check("async_rst_sum", 32'(sum8), 32'd0);
        check("async_rst_cout", 32'(cout8), 32'd0);
        #1;
        rst = 1'b0;
        last_sum = '0; last_cout = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_done |= done8;
        end
        check("no_done_after_rst", 32'(seen_done), 32'd0);
        check("idle_after_rst", 32'(busy8), 32'd0);
        run8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // start held high; operands change while busy and are only taken in the done cycle
        a8 = vecs[0].a; b8 = vecs[0].b; cin8 = vecs[0].cin; start8 = 1'b1;
        tick();
        elapsed = 0;
        for (int k = 0; k < 8; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            wait_done8(cyc);
            check($sformatf("held%0d_done", k), 32'(done8), 32'd1);
            check($sformatf("held%0d_sum", k), 32'(sum8), 32'(vecs[k].exp_sum));
            check($sformatf("held%0d_cout", k), 32'(cout8), 32'(vecs[k].exp_cout));
            if (k < 7) begin
                a8 = vecs[k+1].a; b8 = vecs[k+1].b; cin8 = vecs[k+1].cin;
                tick();
                check($sformatf("held%0d_reaccept", k), 32'(busy8), 32'd1);
                check($sformatf("held%0d_done_drop", k), 32'(done8), 32'd0);
                check($sformatf("held%0d_sum_hold", k), 32'(sum8), 32'(vecs[k].exp_sum));
            end
        end
        start8 = 1'b0;
        last_sum = vecs[7].exp_sum; last_cout = vecs[7].exp_cout;
        tick(); tick();

        // Random N=8
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e9 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            run8($sformatf("rnd8_%0d", i), ra, rb, rc, e9[7:0], e9[8]);
        end

        // Random N=1
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            e2 = {1'b0, a1} + {1'b0, b1} + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            cyc = 0;
            while (done1 !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            check($sformatf("n1_%0d_latency", i), 32'(cyc), 32'd1);
            check($sformatf("n1_%0d_result", i), 32'({cout1, sum1}), 32'(e2));
        end

        // Random N=13
        for (int i = 0; i < 1000; i++) begin
            a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
            e14 = {1'b0, a13} + {1'b0, b13} + 14'(cin13);
            start13 = 1'b1;
            tick();
            start13 = 1'b0;
            cyc = 0;
            while (done13 !== 1'b1 && cyc < 40) begin
                tick();
                cyc++;
            end
            check($sformatf("n13_%0d_latency", i), 32'(cyc), 32'd13);
            check($sformatf("n13_%0d_result", i), 32'({cout13, sum13}), 32'(e14));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
